// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: pops bytes from the ps2_keyboard receive FIFO, decodes
// PS/2 set-2 E0/F0 prefixes, tracks one held key, counts new presses and
// recovers from FIFO overflow by holding clrn low for CLR_CYCLES cycles.
module ps2_scan_ctrl #(
  parameter int CLR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       clrn,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_held,
  output logic       make_pulse,
  output logic       rep_pulse,
  output logic       break_pulse,
  output logic       ovf_pulse,
  output logic [7:0] press_count
);

  localparam int             CNT_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [7:0]     CODE_EXT = 8'hE0;
  localparam logic [7:0]     CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_GAP,
    ST_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ext_f_q, ext_f_d;
  logic             brk_f_q, brk_f_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             clrn_q, clrn_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_held_q, key_held_d;
  logic             make_q, make_d;
  logic             rep_q, rep_d;
  logic             brk_q, brk_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       press_count_q, press_count_d;
  logic             same_key;

  // The incoming byte (with the pending E0 flag) names the key currently held
  assign same_key = key_held_q && (data == held_code_q) && (ext_f_q == held_ext_q);

  // Next-state and next-output computation for the pop/decode/flush sequencer
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    ext_f_d       = ext_f_q;
    brk_f_d       = brk_f_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    nextdata_n_d  = 1'b1;
    clrn_d        = 1'b1;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_held_d    = key_held_q;
    make_d        = 1'b0;
    rep_d         = 1'b0;
    brk_d         = 1'b0;
    ovf_d         = 1'b0;
    press_count_d = press_count_q;

    case (state_q)
      ST_IDLE: begin
        if (overflow) begin
          // Overflow wins over a pending byte: the FIFO contents are dropped
          state_d     = ST_FLUSH;
          flush_cnt_d = CNT_LAST;
          clrn_d      = 1'b0;
          ovf_d       = 1'b1;
          ext_f_d     = 1'b0;
          brk_f_d     = 1'b0;
          key_held_d  = 1'b0;
        end else if (ready) begin
          state_d      = ST_POP;
          nextdata_n_d = 1'b0;
          if (data == CODE_EXT) begin
            ext_f_d = 1'b1;
          end else if (data == CODE_BRK) begin
            brk_f_d = 1'b1;
          end else begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
            if (brk_f_q) begin
              // Release: report it even if it is not the tracked key
              brk_d      = 1'b1;
              key_code_d = data;
              key_ext_d  = ext_f_q;
              if (same_key) begin
                key_held_d = 1'b0;
              end
            end else if (same_key) begin
              // Typematic repeat leaves code, held key and count untouched
              rep_d = 1'b1;
            end else begin
              // New press replaces whatever key was tracked before
              make_d        = 1'b1;
              press_count_d = press_count_q + 8'd1;
              key_code_d    = data;
              key_ext_d     = ext_f_q;
              key_held_d    = 1'b1;
              held_code_d   = data;
              held_ext_d    = ext_f_q;
            end
          end
        end
      end
      ST_POP: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
          clrn_d      = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; clrn is held low throughout reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      nextdata_n_q  <= 1'b1;
      clrn_q        <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_held_q    <= 1'b0;
      make_q        <= 1'b0;
      rep_q         <= 1'b0;
      brk_q         <= 1'b0;
      ovf_q         <= 1'b0;
      press_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      nextdata_n_q  <= nextdata_n_d;
      clrn_q        <= clrn_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_held_q    <= key_held_d;
      make_q        <= make_d;
      rep_q         <= rep_d;
      brk_q         <= brk_d;
      ovf_q         <= ovf_d;
      press_count_q <= press_count_d;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign clrn        = clrn_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_held    = key_held_q;
  assign make_pulse  = make_q;
  assign rep_pulse   = rep_q;
  assign break_pulse = brk_q;
  assign ovf_pulse   = ovf_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Testbench for ps2_scan_ctrl: a queue stands in for the keyboard FIFO,
// a key-event reference model predicts every popped byte's effect.
module tb_ps2_scan_ctrl;

  localparam int EV_NONE = 0;
  localparam int EV_MAKE = 1;
  localparam int EV_REP  = 2;
  localparam int EV_BRK  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;
  logic       clrn;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic       make_pulse;
  logic       rep_pulse;
  logic       break_pulse;
  logic       ovf_pulse;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.CLR_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .clrn        (clrn),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_held    (key_held),
    .make_pulse  (make_pulse),
    .rep_pulse   (rep_pulse),
    .break_pulse (break_pulse),
    .ovf_pulse   (ovf_pulse),
    .press_count (press_count)
  );

  typedef struct {
    logic [7:0] b;
    int         ev;
    logic [7:0] code;
    logic       ext;
    logic       held;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [20];

  int n_vec = 0;
  int n_err = 0;

  // FIFO stand-in and observation counters
  logic [7:0] fifo [$];
  int  since_pop  = 100;
  bit  prev_pop   = 1'b0;
  bit  popped     = 1'b0;
  int  pops       = 0;
  int  make_seen  = 0;
  int  ovf_seen   = 0;
  int  clr_low    = 0;

  // Reference model: key identity is ext*256+code, -1 when nothing is held
  bit         m_ext;
  bit         m_brk;
  int         m_held_id;
  logic [7:0] m_code;
  bit         m_kext;
  int         m_cnt;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held_id = -1; m_code = 8'h00; m_kext = 0; m_cnt = 0;
  endtask

  task automatic model_flush();
    m_ext = 0; m_brk = 0; m_held_id = -1;
  endtask

  function automatic int model_step(input logic [7:0] b);
    int id;
    int ev;
    if (b == 8'hE0) begin
      m_ext = 1;
      return EV_NONE;
    end
    if (b == 8'hF0) begin
      m_brk = 1;
      return EV_NONE;
    end
    id = (m_ext ? 256 : 0) + int'(b);
    if (m_brk) begin
      ev = EV_BRK;
      m_code = b;
      m_kext = m_ext;
      if (id == m_held_id) m_held_id = -1;
    end else if (id == m_held_id) begin
      ev = EV_REP;
    end else begin
      ev = EV_MAKE;
      m_cnt = (m_cnt + 1) % 256;
      m_code = b;
      m_kext = m_ext;
      m_held_id = id;
    end
    m_ext = 0;
    m_brk = 0;
    return ev;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int obs_ev();
    if (make_pulse) return EV_MAKE;
    if (rep_pulse) return EV_REP;
    if (break_pulse) return EV_BRK;
    return EV_NONE;
  endfunction

  task automatic drive();
    ready = (fifo.size() > 0);
    data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive();
  endtask

  // One clock: observe at the falling edge, consume popped bytes, update FIFO
  task automatic tick();
    logic [7:0] b;
    int ev;
    @(negedge clk);
    since_pop++;
    if (!reset && !clrn) clr_low++;
    if (ovf_pulse) ovf_seen++;
    if (make_pulse) make_seen++;
    if (!nextdata_n) begin
      chk("pop_width", 32'(prev_pop), 32'd0);
      chk("pop_spacing", 32'(since_pop >= 3), 32'd1);
      since_pop = 0;
      prev_pop  = 1'b1;
      popped    = 1'b1;
      pops++;
      if (fifo.size() == 0) begin
        chk("pop_nonempty", 32'd0, 32'd1);
      end else begin
        b  = fifo.pop_front();
        ev = model_step(b);
        chk("pulse_kind", 32'(obs_ev()), 32'(ev));
        chk("key_code", 32'(key_code), 32'(m_code));
        chk("key_ext", 32'(key_ext), 32'(m_kext));
        chk("key_held", 32'(key_held), 32'(m_held_id >= 0));
        chk("press_count", 32'(press_count), 32'(m_cnt));
      end
    end else begin
      prev_pop = 1'b0;
      chk("stray_pulse", 32'({make_pulse, rep_pulse, break_pulse}), 32'd0);
    end
    if (!clrn) begin
      fifo.delete();
      overflow = 1'b0;
    end
    drive();
  endtask

  task automatic apply_byte(input logic [7:0] b);
    popped = 1'b0;
    push(b);
    for (int t = 0; t < 20 && !popped; t++) tick();
    if (!popped) chk("pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && fifo.size() > 0; t++) tick();
    chk("drain", 32'(fifo.size()), 32'd0);
    repeat (3) tick();
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return 8'h1C;
      3: return 8'h32;
      4: return 8'h75;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int mk0, o0, c0, p0;
    logic [7:0] c;
    bit e;

    tbl[0]  = '{8'h1C, EV_MAKE, 8'h1C, 1'b0, 1'b1, 8'd1};
    tbl[1]  = '{8'h1C, EV_REP,  8'h1C, 1'b0, 1'b1, 8'd1};
    tbl[2]  = '{8'h1C, EV_REP,  8'h1C, 1'b0, 1'b1, 8'd1};
    tbl[3]  = '{8'hF0, EV_NONE, 8'h1C, 1'b0, 1'b1, 8'd1};
    tbl[4]  = '{8'h1C, EV_BRK,  8'h1C, 1'b0, 1'b0, 8'd1};
    tbl[5]  = '{8'hE0, EV_NONE, 8'h1C, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{8'h75, EV_MAKE, 8'h75, 1'b1, 1'b1, 8'd2};
    tbl[7]  = '{8'hE0, EV_NONE, 8'h75, 1'b1, 1'b1, 8'd2};
    tbl[8]  = '{8'hF0, EV_NONE, 8'h75, 1'b1, 1'b1, 8'd2};
    tbl[9]  = '{8'h75, EV_BRK,  8'h75, 1'b1, 1'b0, 8'd2};
    tbl[10] = '{8'h1C, EV_MAKE, 8'h1C, 1'b0, 1'b1, 8'd3};
    tbl[11] = '{8'h32, EV_MAKE, 8'h32, 1'b0, 1'b1, 8'd4};
    tbl[12] = '{8'hF0, EV_NONE, 8'h32, 1'b0, 1'b1, 8'd4};
    tbl[13] = '{8'h1C, EV_BRK,  8'h1C, 1'b0, 1'b1, 8'd4};
    tbl[14] = '{8'h32, EV_REP,  8'h1C, 1'b0, 1'b1, 8'd4};
    tbl[15] = '{8'hE0, EV_NONE, 8'h1C, 1'b0, 1'b1, 8'd4};
    tbl[16] = '{8'h32, EV_MAKE, 8'h32, 1'b1, 1'b1, 8'd5};
    tbl[17] = '{8'hF0, EV_NONE, 8'h32, 1'b1, 1'b1, 8'd5};
    tbl[18] = '{8'hE0, EV_NONE, 8'h32, 1'b1, 1'b1, 8'd5};
    tbl[19] = '{8'h32, EV_BRK,  8'h32, 1'b1, 1'b0, 8'd5};

    reset = 1'b1; overflow = 1'b0; data = 8'h00; ready = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_clrn", 32'(clrn), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_key_held", 32'(key_held), 32'd0);
    chk("rst_press_count", 32'(press_count), 32'd0);
    chk("rst_pulses", 32'({make_pulse, rep_pulse, break_pulse, ovf_pulse}), 32'd0);
    reset = 1'b0;
    tick();
    chk("clrn_release", 32'(clrn), 32'd1);
    tick();

    // Table-driven decode sequences
    for (int i = 0; i < 20; i++) begin
      apply_byte(tbl[i].b);
      chk("tbl_ev", 32'(obs_ev()), 32'(tbl[i].ev));
      chk("tbl_code", 32'(key_code), 32'(tbl[i].code));
      chk("tbl_ext", 32'(key_ext), 32'(tbl[i].ext));
      chk("tbl_held", 32'(key_held), 32'(tbl[i].held));
      chk("tbl_cnt", 32'(press_count), 32'(tbl[i].cnt));
      if (i == 0) begin
        tick();
        chk("pop_one_cycle", 32'(nextdata_n), 32'd1);
      end
    end

    // Overflow with a byte pending: flush, no pop, flags and held key cleared
    apply_byte(8'h1C);
    apply_byte(8'hE0);
    apply_byte(8'hF0);
    repeat (2) tick();
    o0 = ovf_seen; c0 = clr_low; p0 = pops;
    push(8'h33);
    overflow = 1'b1;
    repeat (5) tick();
    model_flush();
    chk("ovf_pulse_once", 32'(ovf_seen - o0), 32'd1);
    chk("clrn_low_cycles", 32'(clr_low - c0), 32'd2);
    chk("ovf_no_pop", 32'(pops - p0), 32'd0);
    chk("ovf_held_clear", 32'(key_held), 32'd0);
    chk("ovf_code_kept", 32'(key_code), 32'(m_code));
    chk("ovf_count_kept", 32'(press_count), 32'(m_cnt));
    apply_byte(8'h1C);
    chk("post_ovf_make", 32'(make_pulse), 32'd1);
    chk("post_ovf_ext", 32'(key_ext), 32'd0);

    // Reset asserted while a pop is in progress
    apply_byte(8'h5A);
    reset = 1'b1;
    tick();
    model_reset();
    chk("rstpop_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rstpop_clrn", 32'(clrn), 32'd0);
    chk("rstpop_count", 32'(press_count), 32'd0);
    chk("rstpop_held", 32'(key_held), 32'd0);
    reset = 1'b0;
    tick();
    chk("rstpop_clrn_up", 32'(clrn), 32'd1);
    push(8'h1C);
    tick();
    chk("rstpop_idle_pop", 32'(nextdata_n), 32'd0);
    drain();

    // 256 distinct make/break pairs from a fresh reset: count wraps to zero
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    repeat (2) tick();
    mk0 = make_seen;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      e = (c == 8'hE0) || (c == 8'hF0);
      if (e) c = c ^ 8'h01;
      if (e) apply_byte(8'hE0);
      apply_byte(c);
      if (e) apply_byte(8'hE0);
      apply_byte(8'hF0);
      apply_byte(c);
    end
    chk("wrap_makes", 32'(make_seen - mk0), 32'd256);
    chk("wrap_count", 32'(press_count), 32'd0);

    // Random bursts and overflow events against the reference model
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        drain();
        o0 = ovf_seen; c0 = clr_low;
        overflow = 1'b1;
        repeat (5) tick();
        model_flush();
        chk("rnd_ovf_pulse", 32'(ovf_seen - o0), 32'd1);
        chk("rnd_clrn_low", 32'(clr_low - c0), 32'd2);
        chk("rnd_ovf_held", 32'(key_held), 32'd0);
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) push(rand_byte());
        drain();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
